// File: rtl/carry_save_multiplier_26b.sv
// carry_save_multiplier_26b
//   Unsigned 26x26 -> 52-bit array multiplier with one registered output stage.
//   Partial products are reduced through a carry-save adder array, and a final
//   ripple carry-propagate adder resolves the upper half. The array is purely
//   combinational from a/b up to the output register.
//
// Ports
//   mul_out  out 52  registered product a*b (1-cycle latency)
//   a        in  26  unsigned multiplicand
//   b        in  26  unsigned multiplier
//   clk      in   1  clock, rising edge
//   rstn     in   1  synchronous reset, active-high despite the name

module carry_save_multiplier_26b (
  output logic [51:0] mul_out,
  input  logic [25:0] a,
  input  logic [25:0] b,
  input  logic        clk,
  input  logic        rstn
);

  localparam int unsigned W = 26;

  // pp_row[j][i] = a[i] & b[j]
  logic [W-1:0] pp_row [W];
  // Row j outputs. s_row[j][i] carries weight j+i, c_row[j][i] carries weight j+i+1.
  logic [W-1:0] s_row  [W];
  logic [W-1:0] c_row  [W];

  logic [W-1:0] prod_lo;
  logic [W-1:0] prod_hi;
  logic [W-1:0] rca_a;
  logic [W-1:0] rca_b;
  logic [W-1:0] rca_cy;
  logic [51:0]  product_d;

  genvar gi, gj;

  generate
    for (gj = 0; gj < W; gj++) begin : g_pp
      assign pp_row[gj] = a & {W{b[gj]}};
    end
  endgenerate

  // Row 0 is the bare first partial product; there is nothing to add yet.
  assign s_row[0] = pp_row[0];
  assign c_row[0] = '0;

  // Rows 1..25: each cell adds its partial-product bit to the previous row's
  // sum (shifted down one place) and carry at the same weight. No carry moves
  // sideways within a row. Cells with a constant-zero input reduce to half
  // adders in synthesis.
  generate
    for (gj = 1; gj < W; gj++) begin : g_row
      for (gi = 0; gi < W; gi++) begin : g_col
        logic sum_in;
        if (gi < W - 1) begin : g_mid
          assign sum_in = s_row[gj-1][gi+1];
        end else begin : g_top
          assign sum_in = 1'b0;
        end
        csa_full_adder u_fa (
          .x    (pp_row[gj][gi]),
          .y    (sum_in),
          .cin  (c_row[gj-1][gi]),
          .sum  (s_row[gj][gi]),
          .cout (c_row[gj][gi])
        );
      end
    end
  endgenerate

  // The LSB of each row is final: nothing else ever lands on that weight.
  generate
    for (gj = 0; gj < W; gj++) begin : g_lo
      assign prod_lo[gj] = s_row[gj][0];
    end
  endgenerate

  // Final merge at weights 26..51: remaining sum bits and last-row carries.
  assign rca_a  = {1'b0, s_row[W-1][W-1:1]};
  assign rca_b  = c_row[W-1];
  assign rca_cy[0] = 1'b0;

  generate
    for (gi = 0; gi < W - 1; gi++) begin : g_rca
      csa_full_adder u_fa (
        .x    (rca_a[gi]),
        .y    (rca_b[gi]),
        .cin  (rca_cy[gi]),
        .sum  (prod_hi[gi]),
        .cout (rca_cy[gi+1])
      );
    end
  endgenerate

  // Top bit: a 26x26 product never carries out of bit 51, so only the sum is kept.
  assign prod_hi[W-1] = rca_a[W-1] ^ rca_b[W-1] ^ rca_cy[W-1];

  assign product_d = {prod_hi, prod_lo};

  always_ff @(posedge clk) begin
    if (rstn) begin
      mul_out <= 52'h0;
    end else begin
      mul_out <= product_d;
    end
  end

endmodule

// csa_full_adder
//   One-bit full adder cell used throughout the array and the final adder.
//   x, y, cin in; sum, cout out.
module csa_full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic xy;

  assign xy   = x ^ y;
  assign sum  = xy ^ cin;
  assign cout = (x & y) | (cin & xy);

endmodule

// File: tb/tb_carry_save_multiplier_26b.sv
module tb_carry_save_multiplier_26b;

  logic [51:0] mul_out;
  logic [25:0] a;
  logic [25:0] b;
  logic        clk;
  logic        rstn;

  int n_checks;
  int n_fail;

  carry_save_multiplier_26b dut (
    .mul_out (mul_out),
    .a       (a),
    .b       (b),
    .clk     (clk),
    .rstn    (rstn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 52-bit unsigned multiplication.
  function automatic logic [51:0] ref_mul(input logic [25:0] x, input logic [25:0] y);
    logic [51:0] wx;
    logic [51:0] wy;
    wx = {26'b0, x};
    wy = {26'b0, y};
    return wx * wy;
  endfunction

  // Drive operands/reset away from the edge, then let one rising edge pass.
  task automatic step(input logic [25:0] ta, input logic [25:0] tb, input logic tr);
    @(negedge clk);
    a    = ta;
    b    = tb;
    rstn = tr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(26'h3FFFFFF, 26'h3FFFFFF, 1'b1);
      n_checks++;
      if (mul_out !== 52'h0) begin
        n_fail++;
        $display("FAIL reset edge %0d: got %h expected %h", k, mul_out, 52'h0);
      end
    end
  endtask

  task automatic test_max();
    step(26'h3FFFFFF, 26'h3FFFFFF, 1'b0);
    n_checks++;
    if (mul_out !== 52'hFFFFFF8000001) begin
      n_fail++;
      $display("FAIL max_operands: got %h expected %h", mul_out, 52'hFFFFFF8000001);
    end
  endtask

  task automatic test_zero_identity();
    logic [25:0] ta [3];
    logic [25:0] tb [3];
    logic [51:0] te [3];
    ta[0] = 26'h0;       tb[0] = 26'h3FFFFFF; te[0] = 52'h0;
    ta[1] = 26'h1;       tb[1] = 26'h2ABCDEF; te[1] = 52'h2ABCDEF;
    ta[2] = 26'h2000000; tb[2] = 26'h2;       te[2] = 52'h4000000;
    for (int k = 0; k < 3; k++) begin
      step(ta[k], tb[k], 1'b0);
      n_checks++;
      if (mul_out !== te[k]) begin
        n_fail++;
        $display("FAIL zero_identity[%0d]: got %h expected %h", k, mul_out, te[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(26'h1000, 26'h1000, 1'b0);
    n_checks++;
    if (mul_out !== 52'h1000000) begin
      n_fail++;
      $display("FAIL back_to_back edge n: got %h expected %h", mul_out, 52'h1000000);
    end
    step(26'h3, 26'h5, 1'b0);
    n_checks++;
    if (mul_out !== 52'hF) begin
      n_fail++;
      $display("FAIL back_to_back edge n+1: got %h expected %h", mul_out, 52'hF);
    end
    // Holding operands keeps the product steady.
    step(26'h3, 26'h5, 1'b0);
    n_checks++;
    if (mul_out !== 52'hF) begin
      n_fail++;
      $display("FAIL hold_constant: got %h expected %h", mul_out, 52'hF);
    end
  endtask

  task automatic test_mid_reset();
    logic [25:0] ra;
    logic [25:0] rb;
    for (int k = 0; k < 3; k++) begin
      ra = 26'($urandom);
      rb = 26'($urandom);
      step(ra, rb, 1'b0);
      n_checks++;
      if (mul_out !== ref_mul(ra, rb)) begin
        n_fail++;
        $display("FAIL mid_reset stream[%0d]: got %h expected %h", k, mul_out, ref_mul(ra, rb));
      end
    end
    step(26'h3FFFFFF, 26'h3FFFFFF, 1'b1);
    n_checks++;
    if (mul_out !== 52'h0) begin
      n_fail++;
      $display("FAIL mid_reset asserted: got %h expected %h", mul_out, 52'h0);
    end
    step(26'h1234567, 26'h0ABCDEF, 1'b0);
    n_checks++;
    if (mul_out !== ref_mul(26'h1234567, 26'h0ABCDEF)) begin
      n_fail++;
      $display("FAIL mid_reset resume: got %h expected %h", mul_out,
               ref_mul(26'h1234567, 26'h0ABCDEF));
    end
  endtask

  task automatic test_random();
    logic [25:0] ra;
    logic [25:0] rb;
    logic [51:0] exp_q [$];
    logic [51:0] exp_v;
    for (int k = 0; k < 100; k++) begin
      ra = 26'($urandom);
      rb = 26'($urandom);
      // Sprinkle in all-ones operands to stress long carry chains.
      if ($urandom_range(0, 9) == 0) ra = 26'h3FFFFFF;
      if ($urandom_range(0, 9) == 0) rb = 26'h3FFFFFF;
      exp_q.push_back(ref_mul(ra, rb));
      @(negedge clk);
      a    = ra;
      b    = rb;
      rstn = 1'b0;
      @(posedge clk);
      #4;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (mul_out !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h: got %h expected %h", k, ra, rb, mul_out, exp_v);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    a        = '0;
    b        = '0;
    rstn     = 1'b1;
    test_reset();
    test_max();
    test_zero_identity();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
